epcs_read_sequencer: RTL

Sequences the 8-bit SPI master (EPCS flash port) to perform complete flash READ transactions without CPU involvement. Given a 24-bit byte address and a length, it drives the SPI master's register port to assert the slave select, shift out opcode and address, clock in the data bytes, and release the select. Data bytes are delivered on a valid/ready byte stream. It sits between a boot/DMA client and the SPI master, alongside the CPU slave port.

---
 rtl/epcs_read_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/epcs_read_sequencer.sv
// Drives the EPCS SPI master register port to perform a complete flash READ:
// select, opcode + 24-bit address, N data bytes streamed out, deselect.
module epcs_read_sequencer #(
    parameter logic [7:0]  READ_OPCODE = 8'h03,
    parameter logic [15:0] SS_MASK     = 16'h0001,
    parameter logic [7:0]  DUMMY_BYTE  = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_start,
    input  logic [23:0] cmd_addr,
    input  logic [15:0] cmd_len,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        spi_select,
    output logic        spi_read_n,
    output logic        spi_write_n,
    output logic [2:0]  spi_mem_addr,
    output logic [15:0] spi_data_from_cpu,
    input  logic [15:0] spi_data_to_cpu,
    input  logic        spi_readyfordata,
    input  logic        spi_dataavailable
);

    typedef enum logic [3:0] {
        IDLE, SEL, SSO_ON, TX_WAIT, TX_WR, RX_WAIT, RX_RD, OUT, SSO_OFF, DONE
    } state_t;

    state_t      state, state_next;
    logic [1:0]  phase, phase_next;
    logic [23:0] addr_q;
    logic [15:0] remaining;
    logic [2:0]  hdr_cnt;
    logic        is_access;
    logic        bus_active;
    logic        is_data_byte;
    logic [7:0]  tx_byte;
    logic        unused_hi;

    assign unused_hi = &{1'b0, spi_data_to_cpu[15:8]};

    assign is_access    = (state == SEL) || (state == SSO_ON) || (state == TX_WR) ||
                          (state == RX_RD) || (state == SSO_OFF);
    assign bus_active   = is_access && (phase != 2'd2);
    assign is_data_byte = (hdr_cnt == 3'd4);

    always_comb begin
        case (hdr_cnt)
            3'd0:    tx_byte = READ_OPCODE;
            3'd1:    tx_byte = addr_q[23:16];
            3'd2:    tx_byte = addr_q[15:8];
            3'd3:    tx_byte = addr_q[7:0];
            default: tx_byte = DUMMY_BYTE;
        endcase
    end

    // Data-byte reads skip the bus idle cycle: OUT never strobes, so it serves as the idle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_start) state_next = SEL;
            SEL:     if (phase == 2'd2) state_next = SSO_ON;
            SSO_ON:  if (phase == 2'd2) state_next = TX_WAIT;
            TX_WAIT: if (spi_readyfordata) state_next = TX_WR;
            TX_WR:   if (phase == 2'd2) state_next = RX_WAIT;
            RX_WAIT: if (spi_dataavailable) state_next = RX_RD;
            RX_RD: begin
                if (is_data_byte && phase == 2'd1)
                    state_next = OUT;
                else if (phase == 2'd2)
                    state_next = (remaining == 16'd0) && (hdr_cnt == 3'd4) ? SSO_OFF : TX_WAIT;
            end
            OUT:     if (out_ready) state_next = (remaining == 16'd1) ? SSO_OFF : TX_WAIT;
            SSO_OFF: if (phase == 2'd2) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        phase_next = phase;
        if (state_next != state)
            phase_next = 2'd0;
        else if (is_access)
            phase_next = phase + 2'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            phase     <= 2'd0;
            addr_q    <= 24'd0;
            remaining <= 16'd0;
            hdr_cnt   <= 3'd0;
            out_data  <= 8'd0;
        end else begin
            state <= state_next;
            phase <= phase_next;
            if (state == IDLE && cmd_start) begin
                addr_q    <= cmd_addr;
                remaining <= cmd_len;
                hdr_cnt   <= 3'd0;
            end
            if (state == RX_RD && phase == 2'd1) begin
                if (is_data_byte)
                    out_data <= spi_data_to_cpu[7:0];
                else
                    hdr_cnt <= hdr_cnt + 3'd1;
            end
            if (state == OUT && out_ready)
                remaining <= remaining - 16'd1;
        end
    end

    always_comb begin
        spi_select        = bus_active;
        spi_write_n       = !(bus_active && state != RX_RD);
        spi_read_n        = !(bus_active && state == RX_RD);
        spi_mem_addr      = 3'd0;
        spi_data_from_cpu = 16'd0;
        if (bus_active) begin
            case (state)
                SEL:     begin spi_mem_addr = 3'd5; spi_data_from_cpu = SS_MASK;        end
                SSO_ON:  begin spi_mem_addr = 3'd3; spi_data_from_cpu = 16'h0400;       end
                TX_WR:   begin spi_mem_addr = 3'd1; spi_data_from_cpu = {8'h00, tx_byte}; end
                SSO_OFF: begin spi_mem_addr = 3'd3; spi_data_from_cpu = 16'h0000;       end
                default: begin spi_mem_addr = 3'd0; spi_data_from_cpu = 16'h0000;       end
            endcase
        end
    end

    assign cmd_busy  = (state != IDLE);
    assign cmd_done  = (state == DONE);
    assign out_valid = (state == OUT);
    assign out_last  = (state == OUT) && (remaining == 16'd1);

endmodule
